// File: rtl/dbus_arbiter.sv
// Two-master round-robin data-bus arbiter with RAM / I/O / unmapped address decode.
// Each grant runs exactly one word transaction through IDLE -> ACCESS -> RESP.
module dbus_arbiter #(
   parameter int         RAMBITS   = 8,
   parameter logic [3:0] IO_PREFIX = 4'hE
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               m0_req,
   input  logic [31:0]        m0_addr,
   input  logic [31:0]        m0_wdata,
   input  logic               m0_we,
   output logic [31:0]        m0_rdata,
   output logic               m0_ack,
   output logic               m0_err,
   input  logic               m1_req,
   input  logic [31:0]        m1_addr,
   input  logic [31:0]        m1_wdata,
   input  logic               m1_we,
   output logic [31:0]        m1_rdata,
   output logic               m1_ack,
   output logic               m1_err,
   output logic [RAMBITS-1:0] ram_addr,
   output logic [31:0]        ram_wdata,
   output logic               ram_we,
   input  logic [31:0]        ram_rdata,
   output logic               io_cs,
   output logic               io_we,
   output logic [31:0]        io_wdata,
   input  logic [31:0]        io_rdata
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t      state_q, state_d;
   logic        prio_q, prio_d;
   logic        gnt_q, gnt_d;
   logic [31:2] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic        we_q, we_d;
   logic [31:0] rdata0_q, rdata0_d;
   logic [31:0] rdata1_q, rdata1_d;

   logic        isRam, isIo, isUnmapped;
   logic [31:0] rdSel;
   logic        unusedAddrBits;

   // Byte-lane bits are ignored; accesses are always whole words.
   assign unusedAddrBits = ^{m0_addr[1:0], m1_addr[1:0]};

   assign isRam      = (addr_q[31:RAMBITS+2] == '0);
   assign isIo       = !isRam && (addr_q[31:28] == IO_PREFIX);
   assign isUnmapped = !isRam && !isIo;
   assign rdSel      = isRam ? ram_rdata : (isIo ? io_rdata : 32'h0);

   assign m0_rdata = rdata0_q;
   assign m1_rdata = rdata1_q;

   always_comb begin
      state_d   = state_q;
      prio_d    = prio_q;
      gnt_d     = gnt_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      we_d      = we_q;
      rdata0_d  = rdata0_q;
      rdata1_d  = rdata1_q;
      ram_addr  = '0;
      ram_wdata = '0;
      ram_we    = 1'b0;
      io_cs     = 1'b0;
      io_we     = 1'b0;
      io_wdata  = '0;
      m0_ack    = 1'b0;
      m0_err    = 1'b0;
      m1_ack    = 1'b0;
      m1_err    = 1'b0;
      case (state_q)
         IDLE: begin
            // The priority pointer only matters when both masters contend.
            if (m0_req && (!m1_req || !prio_q)) begin
               gnt_d   = 1'b0;
               addr_d  = m0_addr[31:2];
               wdata_d = m0_wdata;
               we_d    = m0_we;
               state_d = ACCESS;
            end else if (m1_req) begin
               gnt_d   = 1'b1;
               addr_d  = m1_addr[31:2];
               wdata_d = m1_wdata;
               we_d    = m1_we;
               state_d = ACCESS;
            end
         end
         ACCESS: begin
            if (isRam) begin
               ram_addr  = addr_q[RAMBITS+1:2];
               ram_wdata = wdata_q;
               ram_we    = we_q;
            end else if (isIo) begin
               io_cs    = 1'b1;
               io_we    = we_q;
               io_wdata = wdata_q;
            end
            if (!we_q) begin
               if (gnt_q) rdata1_d = rdSel;
               else       rdata0_d = rdSel;
            end
            state_d = RESP;
         end
         RESP: begin
            if (gnt_q) begin
               m1_ack = 1'b1;
               m1_err = isUnmapped;
            end else begin
               m0_ack = 1'b1;
               m0_err = isUnmapped;
            end
            prio_d  = ~gnt_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= IDLE;
         prio_q   <= 1'b0;
         gnt_q    <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         we_q     <= 1'b0;
         rdata0_q <= '0;
         rdata1_q <= '0;
      end else begin
         state_q  <= state_d;
         prio_q   <= prio_d;
         gnt_q    <= gnt_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         we_q     <= we_d;
         rdata0_q <= rdata0_d;
         rdata1_q <= rdata1_d;
      end
   end

endmodule

// File: tb/tb_dbus_arbiter.sv
// Scoreboard bench for dbus_arbiter: directed scenarios followed by two randomized masters,
// with expected responses predicted from an address-map / memory model.
module tb_dbus_arbiter;

   localparam int RAMBITS = 8;
   localparam int WORDS   = 1 << RAMBITS;

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   logic               clk = 1'b0;
   logic               reset;
   logic               m0_req, m0_we, m0_ack, m0_err;
   logic [31:0]        m0_addr, m0_wdata, m0_rdata;
   logic               m1_req, m1_we, m1_ack, m1_err;
   logic [31:0]        m1_addr, m1_wdata, m1_rdata;
   logic [RAMBITS-1:0] ram_addr;
   logic [31:0]        ram_wdata, ram_rdata, io_wdata, io_rdata;
   logic               ram_we, io_cs, io_we;

   logic [31:0] ramMem [WORDS];
   bit          ramInitDone;
   logic [31:0] ioValue;

   logic [31:0] shadow [WORDS];
   logic [31:0] lastRead [2];
   exp_t        expQ0 [$];
   exp_t        expQ1 [$];
   logic [31:0] ioQ [$];

   int checks   = 0;
   int failures = 0;

   dbus_arbiter #(.RAMBITS(RAMBITS), .IO_PREFIX(4'hE)) dut (
      .clk(clk), .reset(reset),
      .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_we(m0_we),
      .m0_rdata(m0_rdata), .m0_ack(m0_ack), .m0_err(m0_err),
      .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_we(m1_we),
      .m1_rdata(m1_rdata), .m1_ack(m1_ack), .m1_err(m1_err),
      .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata),
      .io_cs(io_cs), .io_we(io_we), .io_wdata(io_wdata), .io_rdata(io_rdata)
   );

   always #5 clk = ~clk;

   // Behavioural slave: asynchronous-read RAM and a fixed I/O read value.
   always @(posedge clk) begin
      if (!ramInitDone) begin
         foreach (ramMem[i]) ramMem[i] <= '0;
         ramInitDone <= 1'b1;
      end else if (ram_we) begin
         ramMem[ram_addr] <= ram_wdata;
      end
   end
   assign ram_rdata = ramMem[ram_addr];
   assign io_rdata  = ioValue;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Predict one transaction from the address map and the shadow memory.
   task automatic pushExp(input int m, input logic [31:0] addr, input logic [31:0] wdata, input logic we);
      exp_t e;
      int   region;
      if (addr < 4 * WORDS)          region = 0;
      else if (addr[31:28] == 4'hE)  region = 1;
      else                           region = 2;
      if (we) begin
         if (region == 0) shadow[addr / 4] = wdata;
         if (region == 1) ioQ.push_back(wdata);
      end else begin
         lastRead[m] = (region == 0) ? shadow[addr / 4] : ((region == 1) ? ioValue : 32'h0);
      end
      e.rdata = lastRead[m];
      e.err   = (region == 2);
      if (m == 0) expQ0.push_back(e);
      else        expQ1.push_back(e);
   endtask

   task automatic drive(input int m, input logic req, input logic [31:0] addr, input logic [31:0] wdata, input logic we);
      if (m == 0) begin
         m0_req = req; m0_addr = addr; m0_wdata = wdata; m0_we = we;
      end else begin
         m1_req = req; m1_addr = addr; m1_wdata = wdata; m1_we = we;
      end
   endtask

   task automatic applyStimulus(input int m, input logic [31:0] addr, input logic [31:0] wdata, input logic we);
      drive(m, 1'b1, addr, wdata, we);
      pushExp(m, addr, wdata, we);
   endtask

   task automatic waitAck(input int m, input int maxCyc, output int cyc);
      logic a;
      a   = 1'b0;
      cyc = 0;
      while (a !== 1'b1 && cyc < maxCyc) begin
         @(negedge clk);
         cyc++;
         a = (m == 0) ? m0_ack : m1_ack;
      end
      checkOutput((m == 0) ? "m0AckSeen" : "m1AckSeen", a, 1);
   endtask

   task automatic clearModelReadback();
      lastRead[0] = '0;
      lastRead[1] = '0;
   endtask

   task automatic randomMaster(input int m, input int n);
      for (int i = 0; i < n; i++) begin
         int          gap, kind, cyc;
         logic [31:0] a, d;
         logic        w;
         gap = $urandom_range(0, 2);
         if (gap > 0) begin
            drive(m, 1'b0, '0, '0, 1'b0);
            repeat (gap) @(negedge clk);
         end
         kind = $urandom_range(0, 9);
         d    = $urandom;
         w    = 1'($urandom_range(0, 1));
         if (kind < 6) begin
            // Disjoint RAM halves keep the shadow model independent of grant order.
            a = (m == 0 ? $urandom_range(0, 127) : $urandom_range(128, 255)) * 4;
         end else if (kind < 8) begin
            a = {4'hE, 28'($urandom)};
            if (m == 0) w = 1'b0;
         end else begin
            a = 32'h400 + 32'(4 * $urandom_range(0, 4000));
         end
         applyStimulus(m, a, d, w);
         waitAck(m, 40, cyc);
      end
      drive(m, 1'b0, '0, '0, 1'b0);
   endtask

   // Monitor: pops the scoreboard whenever an ack or I/O write strobe appears.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         checkOutput("ackExclusive", 32'(m0_ack & m1_ack), 0);
         checkOutput("strobeExclusive", 32'(ram_we & io_cs), 0);
         if (m0_ack === 1'b1) begin
            checkOutput("m0AckExpected", 32'(expQ0.size() != 0), 1);
            if (expQ0.size() != 0) begin
               e = expQ0.pop_front();
               checkOutput("m0Rdata", m0_rdata, e.rdata);
               checkOutput("m0Err", 32'(m0_err), 32'(e.err));
            end
         end
         if (m1_ack === 1'b1) begin
            checkOutput("m1AckExpected", 32'(expQ1.size() != 0), 1);
            if (expQ1.size() != 0) begin
               e = expQ1.pop_front();
               checkOutput("m1Rdata", m1_rdata, e.rdata);
               checkOutput("m1Err", 32'(m1_err), 32'(e.err));
            end
         end
         if (io_cs === 1'b1 && io_we === 1'b1) begin
            checkOutput("ioWriteExpected", 32'(ioQ.size() != 0), 1);
            if (ioQ.size() != 0) checkOutput("ioWdata", io_wdata, ioQ.pop_front());
         end
      end
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int cyc, expM, who;
      reset = 1'b0;
      drive(0, 1'b0, '0, '0, 1'b0);
      drive(1, 1'b0, '0, '0, 1'b0);
      ioValue = $urandom;
      foreach (shadow[i]) shadow[i] = '0;
      clearModelReadback();

      // Request held through reset must only be granted once reset releases.
      applyStimulus(0, 32'h8, 32'h0, 1'b0);
      repeat (2) begin
         @(negedge clk);
         checkOutput("rstNoAck", 32'(m0_ack), 0);
         checkOutput("rstNoRamWe", 32'(ram_we), 0);
      end
      checkOutput("rstM0Rdata", m0_rdata, 0);
      checkOutput("rstRamAddr", 32'(ram_addr), 0);
      checkOutput("rstIoCs", 32'(io_cs), 0);
      reset = 1'b1;
      waitAck(0, 10, cyc);
      checkOutput("firstGrantLatency", cyc, 2);

      // RAM write then read-back of the same word.
      applyStimulus(0, 32'h10, 32'hDEADBEEF, 1'b1);
      @(negedge clk);
      @(negedge clk);
      checkOutput("wrRamWe", 32'(ram_we), 1);
      checkOutput("wrRamAddr", 32'(ram_addr), 4);
      checkOutput("wrRamWdata", ram_wdata, 32'hDEADBEEF);
      waitAck(0, 10, cyc);
      checkOutput("wrAckLatency", cyc, 1);
      applyStimulus(0, 32'h10, 32'h0, 1'b0);
      waitAck(0, 10, cyc);
      checkOutput("rdAckLatency", cyc, 3);
      checkOutput("rdData", m0_rdata, 32'hDEADBEEF);

      // Unmapped read: error response, zero data, no strobes.
      applyStimulus(0, 32'h00001000, 32'h0, 1'b0);
      @(negedge clk);
      @(negedge clk);
      checkOutput("unmapNoRamWe", 32'(ram_we), 0);
      checkOutput("unmapNoIoCs", 32'(io_cs), 0);
      waitAck(0, 10, cyc);
      checkOutput("unmapErr", 32'(m0_err), 1);
      checkOutput("unmapRdata", m0_rdata, 0);
      drive(0, 1'b0, '0, '0, 1'b0);

      // I/O write from master 1.
      applyStimulus(1, 32'hE0000000, 32'h41, 1'b1);
      @(negedge clk);
      @(negedge clk);
      checkOutput("ioCs", 32'(io_cs), 1);
      checkOutput("ioWe", 32'(io_we), 1);
      checkOutput("ioWdataLow", 32'(io_wdata[7:0]), 32'h41);
      checkOutput("ioNoRamWe", 32'(ram_we), 0);
      waitAck(1, 10, cyc);
      checkOutput("ioAckLatency", cyc, 1);
      checkOutput("ioCsOneCycle", 32'(io_cs), 0);
      drive(1, 1'b0, '0, '0, 1'b0);

      // Fairness: both masters request continuously from a fresh reset.
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      clearModelReadback();
      for (int k = 0; k < 3; k++) begin
         pushExp(0, 32'h0, 32'h0, 1'b0);
         pushExp(1, 32'h4, 32'h0, 1'b0);
      end
      drive(0, 1'b1, 32'h0, 32'h0, 1'b0);
      drive(1, 1'b1, 32'h4, 32'h0, 1'b0);
      expM = 0;
      for (int i = 0; i < 6; i++) begin
         cyc = 0;
         do begin
            @(negedge clk);
            cyc++;
         end while (m0_ack !== 1'b1 && m1_ack !== 1'b1 && cyc < 10);
         who = (m1_ack === 1'b1) ? 1 : ((m0_ack === 1'b1) ? 0 : 2);
         checkOutput("fairOrder", who, expM);
         checkOutput("fairSpacing", cyc, (i == 0) ? 2 : 3);
         if (i == 4) drive(0, 1'b0, '0, '0, 1'b0);
         if (i == 5) drive(1, 1'b0, '0, '0, 1'b0);
         expM = 1 - expM;
      end

      // Reset during ACCESS of a master-1 write aborts it without an ack.
      @(negedge clk);
      drive(1, 1'b1, 32'h320, 32'h12345678, 1'b1);
      @(negedge clk);
      checkOutput("abortInAccess", 32'(ram_we), 1);
      checkOutput("abortRamAddr", 32'(ram_addr), 200);
      shadow[200] = 32'h12345678;
      reset = 1'b0;
      drive(1, 1'b0, '0, '0, 1'b0);
      @(negedge clk);
      checkOutput("abortNoAck", 32'(m1_ack), 0);
      checkOutput("abortNoErr", 32'(m1_err), 0);
      checkOutput("abortRamWe", 32'(ram_we), 0);
      checkOutput("abortRamAddrZero", 32'(ram_addr), 0);
      checkOutput("abortRamWdata", ram_wdata, 0);
      checkOutput("abortIoCs", 32'(io_cs), 0);
      checkOutput("abortM1Rdata", m1_rdata, 0);
      reset = 1'b1;
      clearModelReadback();
      repeat (5) begin
         @(negedge clk);
         checkOutput("abortStaysQuiet", 32'(m1_ack), 0);
      end

      // Randomized traffic from both masters concurrently.
      fork
         randomMaster(0, 40);
         randomMaster(1, 40);
      join
      repeat (3) @(negedge clk);
      checkOutput("expQ0Drained", expQ0.size(), 0);
      checkOutput("expQ1Drained", expQ1.size(), 0);
      checkOutput("ioQDrained", ioQ.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/dbus_arbiter.md
Name: dbus_arbiter

Overview:
- Two-master, single-slave data-bus arbiter and address decoder for the cpu32 system.
- Shares the single-port data RAM and the memory-mapped I/O window between the CPU data port (master 0) and a secondary master such as a loader or DMA engine (master 1).
- Round-robin arbitration, one word transaction per grant.
- Decodes each address to RAM, I/O or unmapped, and returns an error response for unmapped addresses.

Parameters:
- RAMBITS, 8, word-address width of the data RAM; the RAM window is bytes 0 .. 4*2^RAMBITS-1.
- IO_PREFIX, 4'hE, value of addr[31:28] that selects the I/O window.

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-low reset (0 = reset asserted).
- m0_req  input  1  master 0 request; level, held until m0_ack.
- m0_addr  input  32  master 0 byte address; word aligned, bits [1:0] ignored.
- m0_wdata  input  32  master 0 write data.
- m0_we  input  1  master 0 write (1) / read (0).
- m0_rdata  output  32  master 0 read data; valid while m0_ack=1.
- m0_ack  output  1  master 0 transaction complete (1-cycle pulse).
- m0_err  output  1  master 0 unmapped-address error; qualifies m0_ack.
- m1_req, m1_addr, m1_wdata, m1_we, m1_rdata, m1_ack, m1_err: same as master 0, for master 1.
- ram_addr  output  RAMBITS  RAM word address.
- ram_wdata  output  32  RAM write data.
- ram_we  output  1  RAM write enable.
- ram_rdata  input  32  RAM read data; combinational from ram_addr.
- io_cs  output  1  I/O window select.
- io_we  output  1  I/O write strobe.
- io_wdata  output  32  I/O write data.
- io_rdata  input  32  I/O read data; combinational.

Behaviour:
- State machine: IDLE, ACCESS, RESP.
- Reset (reset=0 at a posedge):
  - state=IDLE; priority pointer=master 0.
  - All acks, errs and strobes (ram_we, io_cs, io_we) = 0.
  - ram_addr, ram_wdata, io_wdata, m0_rdata, m1_rdata = 0.
  - Reset overrides any in-flight transaction; no ack is issued for an aborted access.
- IDLE:
  - If no req, stay in IDLE.
  - If exactly one req, grant that master.
  - If both req, grant the master named by the priority pointer.
  - On grant, latch master id, addr, wdata and we into internal registers; go to ACCESS.
- ACCESS (exactly one cycle):
  - Decode the latched addr:
    - RAM when addr[31:RAMBITS+2]==0.
    - I/O when addr[31:28]==IO_PREFIX.
    - Otherwise unmapped.
  - RAM: ram_addr=addr[RAMBITS+1:2], ram_wdata=wdata, ram_we=we.
  - I/O: io_cs=1, io_we=we, io_wdata=wdata.
  - Unmapped: no strobe asserted.
  - Read data (ram_rdata or io_rdata) is captured into the granted master's rdata register at the end of the cycle. Unmapped reads capture 32'h0.
  - Go to RESP.
- RESP (exactly one cycle):
  - Granted master's ack=1; err=1 if unmapped.
  - Other master's ack/err = 0.
  - Priority pointer moves to the non-granted master.
  - Go to IDLE.
  - req lines are not sampled in RESP.
- Latency:
  - req sampled at edge k; ACCESS in cycle k+1; ack in cycle k+2.
  - Minimum 3 cycles per transaction, so back-to-back throughput is one transaction per 3 cycles.
- Masters:
  - Each master must hold req, addr, wdata and we stable until it sees ack.
  - A req still high in the cycle after ack is a new transaction.
  - A master that drops req before grant simply withdraws.
  - A master that drops req after grant still receives its ack.
- Fairness: with both masters requesting continuously, grants alternate 0,1,0,1; the maximum wait is one transaction.
- RAM and I/O strobes are asserted only in ACCESS, and at most one of ram_we / io_cs is high in any cycle.
- rdata registers hold their value until the next read by the same master.

Test Plan:
- Reset low for 2 cycles while m0_req=1 -> no ack, ram_we=0; first grant occurs only after reset returns high.
- m0 writes 32'hDEADBEEF to 0x10, then reads 0x10 -> ram_we=1 with ram_addr=4 in the ACCESS cycle; read ack 3 cycles after req with m0_rdata=32'hDEADBEEF, err=0.
- m0 and m1 both request continuously from reset, m0 to 0x0 and m1 to 0x4 -> acks alternate m0, m1, m0, m1, each 3 cycles apart; no cycle has both acks high.
- m1 writes 32'h41 to 0xE0000000 -> io_cs=1 and io_we=1 for exactly one cycle with io_wdata[7:0]=8'h41; ram_we=0 throughout.
- m0 reads 0x00001000 with RAMBITS=8 (unmapped) -> m0_ack=1 and m0_err=1, m0_rdata=0, no RAM or I/O strobe.
- Reset asserted during ACCESS of an m1 write -> ack never issued; state=IDLE and all outputs at reset values on the next cycle.
